reg_2bytes_uart_tx: RTL and testbench

- Transmit-side counterpart of the two-byte UART receive register.
- On a send request, latches two bytes and serializes them back-to-back on a single UART TX line: first byte, then second byte, each 8N1, LSB first.
- Reports busy while transmitting and pulses done when both frames are complete.
- Sits between the FPGA command/response logic and the board's UART TX pin.

---
 rtl/reg_2bytes_uart_tx.sv | 150 +++++++++++++++
 tb/tb_reg_2bytes_uart_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reg_2bytes_uart_tx.sv
// ============================================================================
// Module   : reg_2bytes_uart_tx
// Brief    : Latches two bytes and sends them as two back-to-back 8N1 UART
//            frames (first byte, then second byte, LSB first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_2bytes_uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] in_first,
    input  logic [7:0] in_second,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] c_baud_max = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q,  baud_d;
    logic [2:0]     bit_q,   bit_d;
    logic           byte_q,  byte_d;
    logic [15:0]    shift_q, shift_d;
    logic           armed_q, armed_d;
    logic           busy_q,  busy_d;
    logic           done_q,  done_d;
    logic           w_baud_end;

    assign w_baud_end = (baud_q == c_baud_max);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= 1'b0;
            shift_q <= '0;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        armed_d = armed_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                // A request is accepted only after send has been seen low here
                if (!send) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    shift_d = {in_second, in_first};
                    armed_d = 1'b0;
                    byte_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[15:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    baud_d = '0;
                    if (!byte_q) begin
                        byte_d  = 1'b1;
                        state_d = S_START;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Line driven straight from state so an asynchronous reset idles it at once
    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_2bytes_uart_tx.sv
// ============================================================================
// Module   : tb_reg_2bytes_uart_tx
// Brief    : Directed self-checking bench for reg_2bytes_uart_tx (4 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_2bytes_uart_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       send  = 1'b0;
    logic [7:0] in_first  = 8'h00;
    logic [7:0] in_second = 8'h00;
    logic       tx;
    logic       busy;
    logic       done;

    int tests_run    = 0;
    int tests_failed = 0;

    reg_2bytes_uart_tx #(.CLKS_PER_BIT(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .send     (send),
        .in_first (in_first),
        .in_second(in_second),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line image of both frames, element 0 transmitted first
    function automatic logic [19:0] build(input logic [7:0] f, input logic [7:0] s);
        return {1'b1, s, 1'b0, 1'b1, f, 1'b0};
    endfunction

    // Caller leaves send=1 (armed); the first tick is the accepting edge
    task automatic frame(input logic [19:0] v, input bit disturb, input string tag);
        for (int k = 1; k <= 80; k++) begin
            if (disturb && k == 10) begin
                in_first  = 8'hAA;
                in_second = 8'hBB;
                send      = 1'b0;
            end
            if (disturb && k == 11) send = 1'b1;
            tick();
            check({tag, "_tx"}, 16'(tx), 16'(v[(k-1)/4]));
            check({tag, "_busy"}, 16'(busy), 16'd1);
            check({tag, "_nodone"}, 16'(done), 16'd0);
        end
        tick();
        check({tag, "_done"}, 16'(done), 16'd1);
        check({tag, "_busy_end"}, 16'(busy), 16'd0);
        check({tag, "_tx_end"}, 16'(tx), 16'd1);
    endtask

    initial begin
        logic [19:0] vec;

        // 1. Reset state, then asynchronous assertion mid-cycle
        #12;
        check("rst_tx", 16'(tx), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        #5 reset = 1'b1;
        tick();

        // 2. Basic frame 0x55 / 0xA3 against the hand-written line image
        send = 1'b0;
        tick();
        in_first  = 8'h55;
        in_second = 8'hA3;
        send      = 1'b1;
        vec = 20'b1101_0001_1010_1010_1010;
        frame(vec, 1'b0, "basic");
        send = 1'b0;
        tick();
        check("basic_done_once", 16'(done), 16'd0);

        // 3. Held request: one transmission only, then re-arm with one low cycle
        in_first  = 8'h12;
        in_second = 8'h34;
        send      = 1'b1;
        frame(build(8'h12, 8'h34), 1'b0, "held");
        for (int i = 0; i < 219; i++) begin
            tick();
            check("held_idle_busy", 16'(busy), 16'd0);
            check("held_idle_tx", 16'(tx), 16'd1);
            check("held_idle_done", 16'(done), 16'd0);
        end
        send = 1'b0;
        tick();
        send = 1'b1;
        frame(build(8'h12, 8'h34), 1'b0, "held2");

        // 4. Inputs and send toggling while busy are ignored
        send = 1'b0;
        tick();
        in_first  = 8'hF0;
        in_second = 8'h0F;
        send      = 1'b1;
        frame(build(8'hF0, 8'h0F), 1'b1, "immune");
        for (int i = 0; i < 8; i++) begin
            tick();
            check("immune_single_busy", 16'(busy), 16'd0);
            check("immune_single_done", 16'(done), 16'd0);
        end

        // 5. Reset during bit 3 of the second byte
        send = 1'b0;
        tick();
        in_first  = 8'hC3;
        in_second = 8'h5A;
        send      = 1'b1;
        vec = build(8'hC3, 8'h5A);
        for (int k = 1; k <= 58; k++) begin
            tick();
            check("midrst_tx", 16'(tx), 16'(vec[(k-1)/4]));
        end
        #3 reset = 1'b0;
        #1;
        check("midrst_tx_async", 16'(tx), 16'd1);
        check("midrst_busy_async", 16'(busy), 16'd0);
        check("midrst_done_async", 16'(done), 16'd0);
        #12 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("postrst_tx", 16'(tx), 16'd1);
            check("postrst_busy", 16'(busy), 16'd0);
            check("postrst_done", 16'(done), 16'd0);
        end
        send = 1'b0;
        tick();
        send = 1'b1;
        frame(build(8'hC3, 8'h5A), 1'b0, "postrst");

        // 6. Back-to-back: drop send on the done cycle, raise on the next
        send = 1'b0;
        tick();
        check("b2b_gap_tx", 16'(tx), 16'd1);
        check("b2b_gap_busy", 16'(busy), 16'd0);
        in_first  = 8'h81;
        in_second = 8'h7E;
        send      = 1'b1;
        frame(build(8'h81, 8'h7E), 1'b0, "b2b");
        send = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
